// File: rtl/emisor_bits_pkg.sv
// emisor_bits_pkg: quotient-bit line codes and transmitter FSM states.
`default_nettype none
package emisor_bits_pkg;

  localparam logic [1:0] P_N = 2'b00;
  localparam logic [1:0] P_0 = 2'b10;
  localparam logic [1:0] P_1 = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CLR  = 2'b01,
    S_BIT  = 2'b10,
    S_GAP  = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/emisor_bits.sv
// emisor_bits: latches an N-bit word and sends it MSB first as P_0/P_1 pulses,
// each followed by a P_N gap, preceded by one receiver-clear cycle.
`default_nettype none
module emisor_bits
  import emisor_bits_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dato,
  output logic [1:0]   o_a,
  output logic         o_clr,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = $clog2(N + 1);

  state_t         state, state_nxt;
  logic [N-1:0]   shreg, shreg_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [1:0]     a_nxt;
  logic           clr_nxt, busy_nxt, done_nxt;

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    a_nxt     = P_N;
    clr_nxt   = 1'b0;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (i_start) begin
          state_nxt = S_CLR;
          shreg_nxt = i_dato;
          cnt_nxt   = CW'(N);
          clr_nxt   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_CLR: begin
        state_nxt = S_BIT;
        a_nxt     = shreg[N-1] ? P_1 : P_0;
        shreg_nxt = shreg << 1;
        cnt_nxt   = cnt - CW'(1);
      end
      S_BIT: begin
        state_nxt = S_GAP;
        done_nxt  = (cnt == '0);
      end
      S_GAP: begin
        if (cnt != '0) begin
          state_nxt = S_BIT;
          a_nxt     = shreg[N-1] ? P_1 : P_0;
          shreg_nxt = shreg << 1;
          cnt_nxt   = cnt - CW'(1);
        end else begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      o_a    <= P_N;
      o_clr  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      o_a    <= a_nxt;
      o_clr  <= clr_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_emisor_bits.sv
// tb_emisor_bits: directed checks of emisor_bits with a small change-triggered receiver model.
`default_nettype none
module tb_emisor_bits;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [7:0] i_dato;
  logic [1:0] o_a;
  logic       o_clr, o_busy, o_done;

  int passed = 0;
  int total  = 0;

  emisor_bits #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_start(i_start),
    .i_dato (i_dato),
    .o_a    (o_a),
    .o_clr  (o_clr),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 clk = ~clk;

  // Receiver: clears on o_clr, shifts in a bit whenever the code changes to P_0/P_1.
  logic [7:0] rx_q = 8'h00;
  logic [1:0] rx_prev = 2'b00;
  always @(posedge clk) begin
    if (o_clr) rx_q <= 8'h00;
    else if (o_a != rx_prev && o_a != 2'b00) rx_q <= {rx_q[6:0], (o_a == 2'b01)};
    rx_prev <= o_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Start a transfer and check every cycle; codes lists expected bit codes MSB first.
  // At cycle poke (relative to the accepting edge) a new request with 8'hFF is presented.
  task automatic xfer(input logic [7:0] w, input logic [15:0] codes, input int poke);
    logic [1:0] ec;
    i_dato  = w;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk($sformatf("%h clr", w), {o_a, o_clr, o_busy, o_done}, 16'b00110);
    for (int c = 2; c <= 17; c++) begin
      tick();
      if (c % 2 == 0) begin
        ec = codes[15 - (c - 2) -: 2];
        chk($sformatf("%h bit c%0d", w, c), {o_a, o_clr, o_busy, o_done}, {11'd0, ec, 3'b010});
      end else begin
        chk($sformatf("%h gap c%0d", w, c), {o_a, o_clr, o_busy, o_done},
            {14'd0, 1'b1, (c == 17)});
      end
      if (c == poke) begin
        i_start = 1'b1;
        i_dato  = 8'hFF;
      end else begin
        i_start = 1'b0;
      end
    end
    tick();
    chk($sformatf("%h after", w), {o_a, o_clr, o_busy, o_done}, 16'd0);
    chk($sformatf("%h rx_q", w), {8'd0, rx_q}, {8'd0, w});
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int clr_at[$];
    int done_at[$];

    reset   = 1'b1;
    i_start = 1'b0;
    i_dato  = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle %0d", i), {o_a, o_clr, o_busy, o_done}, 16'd0);
    end

    xfer(8'hA5, 16'b01_10_01_10_10_01_10_01, -1);
    tick();
    xfer(8'h00, 16'b10_10_10_10_10_10_10_10, -1);
    xfer(8'hFF, 16'b01_01_01_01_01_01_01_01, -1);
    xfer(8'h3C, 16'b10_10_01_01_01_01_10_10, -1);
    xfer(8'h81, 16'b01_10_10_10_10_10_10_01, 5);
    i_start = 1'b0;
    tick();
    chk("poke ignored", {o_a, o_clr, o_busy, o_done}, 16'd0);

    // Abort mid-transfer.
    i_dato  = 8'hC3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort t+7", {o_a, o_clr, o_busy, o_done}, 16'd0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      done_cnt += int'(o_done);
      busy_cnt += int'(o_busy);
    end
    chk("abort no done", 16'(done_cnt), 16'd0);
    chk("abort no busy", 16'(busy_cnt), 16'd0);
    xfer(8'h5A, 16'b10_01_10_01_01_10_01_10, -1);

    // Reset and start together: request dropped.
    reset   = 1'b1;
    i_start = 1'b1;
    tick();
    reset   = 1'b0;
    i_start = 1'b0;
    chk("rst+start", {o_a, o_clr, o_busy, o_done}, 16'd0);
    tick();
    chk("rst+start next", {o_a, o_clr, o_busy, o_done}, 16'd0);

    // Continuous request: transfers every 18 cycles.
    i_dato  = 8'h96;
    i_start = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      tick();
      if (o_clr) clr_at.push_back(c);
      if (o_done) done_at.push_back(c);
    end
    i_start = 1'b0;
    chk("hold clr count", 16'(clr_at.size()), 16'd3);
    chk("hold done count", 16'(done_at.size()), 16'd3);
    if (clr_at.size() == 3) begin
      chk("hold clr0", 16'(clr_at[0]), 16'd1);
      chk("hold clr1", 16'(clr_at[1]), 16'd19);
      chk("hold clr2", 16'(clr_at[2]), 16'd37);
    end
    if (done_at.size() == 3) begin
      chk("hold done0", 16'(done_at[0]), 16'd17);
      chk("hold done1", 16'(done_at[1]), 16'd35);
      chk("hold done2", 16'(done_at[2]), 16'd53);
    end
    for (int i = 0; i < 20; i++) tick();
    chk("hold drained", {o_a, o_clr, o_busy, o_done}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
